// File: rtl/mat4_job_sequencer.sv
// Job sequencer for the 4x4 matrix-multiply core: buffers host operands, streams them
// into the core, collects the 16 results and aborts jobs on which the core stops progressing.
module mat4_job_sequencer #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              mm_ready,
    output logic              mm_data_valid,
    output logic [DATA_W-1:0] mm_data,
    input  logic              mm_data_done,
    input  logic              mm_calc_done,
    input  logic [DATA_W-1:0] mm_result,
    output logic              mm_read_done
);
    localparam int unsigned N_OPS    = 32;
    localparam int unsigned N_RES    = 16;
    localparam int unsigned WD_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WD_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_SEND, S_WAIT_DD, S_READ, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        wcnt, wcnt_nxt;
    logic [4:0]        rcnt, rcnt_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              err_nxt, busy_nxt, done_nxt, valid_nxt, read_done_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              xfer, capture, progress, job_active;

    logic [DATA_W-1:0] opbuf  [N_OPS];
    logic [DATA_W-1:0] resbuf [N_RES];

    function automatic logic is_busy(input state_t s);
        return (s == S_WAIT_RDY) || (s == S_SEND) || (s == S_WAIT_DD) || (s == S_READ);
    endfunction

    // Next-state, counters, watchdog and next output values
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        rcnt_nxt  = rcnt;
        err_nxt   = err;
        wd_nxt    = '0;
        xfer      = mm_data_valid && mm_ready && (state == S_SEND);
        capture   = (state == S_READ) && mm_calc_done && !mm_read_done;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT_RDY;
                    wcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_WAIT_RDY: begin
                if (mm_ready) state_nxt = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    wcnt_nxt = wcnt + 5'd1;
                    // data_done is only honoured together with or after the last word
                    if (wcnt == 5'(N_OPS - 1)) state_nxt = mm_data_done ? S_READ : S_WAIT_DD;
                end
            end
            S_WAIT_DD: begin
                if (mm_data_done) state_nxt = S_READ;
            end
            S_READ: begin
                if (capture) rcnt_nxt = rcnt + 5'd1;
                if (mm_read_done && (rcnt == 5'(N_RES))) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        job_active = is_busy(state);
        progress   = xfer || capture || (state_nxt != state);
        if (!progress && job_active && (TIMEOUT_CYCLES != 0)) begin
            if (wd == WD_W'(WD_LIMIT)) begin
                state_nxt = S_IDLE;
                err_nxt   = 1'b1;
            end else begin
                wd_nxt = wd + WD_W'(1);
            end
        end

        busy_nxt      = is_busy(state_nxt);
        done_nxt      = (state_nxt == S_DONE);
        valid_nxt     = (state_nxt == S_SEND);
        data_nxt      = valid_nxt ? opbuf[wcnt_nxt] : '0;
        read_done_nxt = capture && (state_nxt == S_READ);
    end

    // State, counters and registered outputs
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state         <= S_IDLE;
            wcnt          <= '0;
            rcnt          <= '0;
            wd            <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mm_data_valid <= 1'b0;
            mm_data       <= '0;
            mm_read_done  <= 1'b0;
            rd_data       <= '0;
        end else begin
            state         <= state_nxt;
            wcnt          <= wcnt_nxt;
            rcnt          <= rcnt_nxt;
            wd            <= wd_nxt;
            err           <= err_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            mm_data_valid <= valid_nxt;
            mm_data       <= data_nxt;
            mm_read_done  <= read_done_nxt;
            rd_data       <= resbuf[rd_addr];
        end
    end

    // Operand and result storage survive reset
    always_ff @(posedge iClk) begin
        if (wr_en && ((state == S_IDLE) || (state == S_DONE))) opbuf[wr_addr] <= wr_data;
        if (capture) resbuf[rcnt[3:0]] <= mm_result;
    end

endmodule

// File: tb/tb_mat4_job_sequencer.sv
// Bench for mat4_job_sequencer: a behavioural core model plus scoreboards for the
// operand stream and the result buffer.
module tb_mat4_job_sequencer;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO    = 16;
    localparam logic [31:0] ONE_F  = 32'h3F80_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [3:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy, done, err;
    logic              mm_ready, mm_data_valid, mm_data_done, mm_calc_done, mm_read_done;
    logic [DATA_W-1:0] mm_data, mm_result;

    mat4_job_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .iClk(clk), .iRstn(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .mm_ready(mm_ready), .mm_data_valid(mm_data_valid), .mm_data(mm_data),
        .mm_data_done(mm_data_done), .mm_calc_done(mm_calc_done),
        .mm_result(mm_result), .mm_read_done(mm_read_done)
    );

    always #5 clk = ~clk;

    int          n_vec, n_err;
    logic [31:0] opmodel [32];
    logic [31:0] exp_tx  [$];
    logic [31:0] exp_res [$];

    // core model state
    int          cyc, rx_cnt, res_idx, phase;
    logic [31:0] rx [32];
    bit          bp_mode, dd_same, dd_never;
    int          clr_req, clr_seen;
    int          tot_tx, tot_rdp, tot_done;
    int          job_first_cyc, job_last_cyc, last_xfer_cyc, err_rise_cyc;
    bit          prev_rdn, prev_done, prev_err, prev_valid, prev_ready;
    logic [31:0] prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Small positive integer to IEEE-754 single
    function automatic logic [31:0] int_to_float(input int n);
        int          e;
        logic [31:0] m;
        e = 0;
        for (int b = 0; b < 30; b++) if (n >= (1 << b)) e = b;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // Core model and stream monitor; inputs for the next rising edge are set each falling edge
    initial begin
        mm_ready = 1'b0; mm_data_done = 1'b0; mm_calc_done = 1'b0; mm_result = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mm_read_done) begin
                tot_rdp++;
                check_eq("rdone_width", 32'(prev_rdn), 32'd0);
            end
            if (done) begin
                tot_done++;
                check_eq("done_width", 32'(prev_done), 32'd0);
            end
            if (err && !prev_err) err_rise_cyc = cyc;
            prev_rdn = mm_read_done; prev_done = done; prev_err = err;

            if (!rst_n || (clr_req != clr_seen)) begin
                clr_seen = clr_req;
                rx_cnt = 0; res_idx = 0; phase = 0;
                mm_ready = 1'b0; mm_data_done = 1'b0; mm_calc_done = 1'b0;
            end else if (phase == 0) begin
                if (rx_cnt < 32) begin
                    mm_ready = bp_mode ? (((cyc / 3) % 2) == 0) : 1'b1;
                    if (mm_data_valid && prev_valid && !prev_ready)
                        check_eq("data_hold", mm_data, prev_data);
                    if (mm_data_valid && mm_ready) begin
                        check_eq("tx_pending", 32'(exp_tx.size() != 0), 32'd1);
                        if (exp_tx.size() != 0) check_eq("tx_word", mm_data, exp_tx.pop_front());
                        if (rx_cnt == 0)  job_first_cyc = cyc;
                        if (rx_cnt == 31) job_last_cyc  = cyc;
                        rx[rx_cnt] = mm_data;
                        rx_cnt++;
                        tot_tx++;
                        last_xfer_cyc = cyc + 1;    // first falling edge after the transfer edge
                        if (rx_cnt == 32 && dd_same && !dd_never) begin
                            mm_data_done = 1'b1; mm_calc_done = 1'b1;
                            mm_result = rx[16]; res_idx = 0; phase = 1;
                        end
                    end
                end else begin
                    mm_ready = 1'b0;
                    if (!dd_never) begin
                        mm_data_done = 1'b1; mm_calc_done = 1'b1;
                        mm_result = rx[16]; res_idx = 0; phase = 1;
                    end
                end
            end else begin
                mm_ready = 1'b0;
                if (mm_read_done) begin
                    res_idx++;
                    if (res_idx == 16) begin
                        mm_data_done = 1'b0; mm_calc_done = 1'b0;
                        phase = 0; rx_cnt = 0; res_idx = 0;
                    end else begin
                        mm_result = rx[16 + res_idx];
                    end
                end
            end
            prev_valid = mm_data_valid; prev_ready = mm_ready; prev_data = mm_data;
        end
    end

    // A = identity, B[i] = float(i + 1 + boff)
    task automatic load_ops(input int boff);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            if (i < 16) wr_data = ((i % 5) == 0) ? ONE_F : 32'd0;
            else        wr_data = int_to_float(i - 16 + 1 + boff);
            opmodel[i] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_results();
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            if (exp_res.size() == 0) break;
            e = exp_res.pop_front();
            @(negedge clk);
            rd_addr = 4'(i);
            @(negedge clk);
            if (i == 5) check_eq("rd_addr5", rd_data, e);
            else        check_eq("result", rd_data, e);
        end
    endtask

    task automatic run_job(input bit expect_done, input bit inject);
        int tx0, rdp0, done0;
        bit saw_done, injected, finished;
        tx0 = tot_tx; rdp0 = tot_rdp; done0 = tot_done;
        saw_done = 1'b0; injected = 1'b0; finished = 1'b0;
        for (int i = 0; i < 32; i++) exp_tx.push_back(opmodel[i]);
        for (int i = 0; i < 16; i++) exp_res.push_back(opmodel[16 + i]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("err_clr", 32'(err), 32'd0);
        check_eq("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (done) saw_done = 1'b1;
            if (inject && !injected && mm_data_valid) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
                injected = 1'b1;
            end
            if (saw_done || err) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0; wr_en = 1'b0;
        check_eq("job_end", 32'(finished), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("tx_count", 32'(tot_tx - tx0), 32'd32);
        check_eq("busy_end", 32'(busy), 32'd0);
        if (expect_done) begin
            check_eq("done_count", 32'(tot_done - done0), 32'd1);
            check_eq("rdone_count", 32'(tot_rdp - rdp0), 32'd16);
            check_eq("err_end", 32'(err), 32'd0);
            check_results();
        end else begin
            check_eq("err_set", 32'(err), 32'd1);
            check_eq("no_done", 32'(tot_done - done0), 32'd0);
            exp_res.delete();
        end
    endtask

    initial begin
        bit found;
        int rdp0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
        bp_mode = 1'b0; dd_same = 1'b0; dd_never = 1'b0; clr_req = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_valid", 32'(mm_data_valid), 32'd0);
        check_eq("rst_rdone", 32'(mm_read_done), 32'd0);
        check_eq("rst_mm_data", mm_data, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;

        // identity x B, always-ready core, data_done together with the last word
        dd_same = 1'b1;
        load_ops(0);
        run_job(1'b1, 1'b0);
        check_eq("tx_back_to_back", 32'(job_last_cyc - job_first_cyc), 32'd31);
        check_eq("word16", rx[16], ONE_F);

        // backpressure on mm_ready, data_done one cycle after the last word
        bp_mode = 1'b1; dd_same = 1'b0;
        load_ops(16);
        run_job(1'b1, 1'b0);

        // start and operand write during SEND are ignored; next job still sends opbuf[0] = 1.0
        bp_mode = 1'b0;
        run_job(1'b1, 1'b1);
        run_job(1'b1, 1'b0);

        // watchdog: core never reports data_done
        dd_never = 1'b1; clr_req++;
        run_job(1'b0, 1'b0);
        check_eq("wd_latency", 32'(err_rise_cyc - last_xfer_cyc), 32'(TMO));
        repeat (3) @(negedge clk);
        check_eq("err_sticky", 32'(err), 32'd1);
        dd_never = 1'b0; clr_req++;
        run_job(1'b1, 1'b0);

        // reset in the middle of the result phase
        load_ops(40);
        for (int i = 0; i < 32; i++) exp_tx.push_back(opmodel[i]);
        rdp0 = tot_rdp; found = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tot_rdp - rdp0 >= 7) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_mid_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_valid", 32'(mm_data_valid), 32'd0);
        check_eq("arst_rdone", 32'(mm_read_done), 32'd0);
        check_eq("arst_mm_data", mm_data, 32'd0);
        check_eq("arst_rd_data", rd_data, 32'd0);
        exp_tx.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_job(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/mat4_job_sequencer.md
Name: mat4_job_sequencer

Overview:
- Front-end sequencer for the 4x4 x 4x4 floating-point matrix-multiply core.
- Host loads matrix A and matrix B into a 32-entry operand buffer, then pulses start.
- Block streams the 32 operand words into the core's ready/data_valid/data interface and collects the 16 result words via calc_done/result/read_done.
- Results land in a 16-entry result buffer readable by the host; a watchdog aborts stalled jobs.

Parameters:
- DATA_W, 32, operand/result word width (IEEE-754 single).
- TIMEOUT_CYCLES, 4096, max cycles without core progress before abort; 0 disables the watchdog.

Ports:
- iClk  in  1  clock.
- iRstn  in  1  asynchronous active-low reset.
- wr_en  in  1  host operand write strobe.
- wr_addr  in  5  operand index: 0-15 = A row-major, 16-31 = B row-major.
- wr_data  in  DATA_W  operand word.
- start  in  1  one-cycle job start request.
- rd_addr  in  4  result index, row-major.
- rd_data  out  DATA_W  registered result word, 1-cycle latency.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when all 16 results are stored.
- err  out  1  sticky watchdog abort flag; cleared by the next accepted start.
- mm_ready  in  1  core idle / accepting operands.
- mm_data_valid  out  1  operand word valid.
- mm_data  out  DATA_W  operand word.
- mm_data_done  in  1  core has received all 32 operands.
- mm_calc_done  in  1  core result word valid on mm_result.
- mm_result  in  DATA_W  result word.
- mm_read_done  out  1  one-cycle pulse: current result consumed.

Behaviour:
- Reset (async, iRstn=0): state IDLE; busy, done, err, mm_data_valid, mm_read_done = 0; mm_data and rd_data = 0; counters = 0. Buffer contents are not cleared.
- Operand writes are accepted only in IDLE or DONE; wr_en in other states is ignored.
- start is accepted only in IDLE; in any other state it is ignored. An accepted start clears err, zeroes the word and result counters and the watchdog, and enters WAIT_RDY.
- WAIT_RDY: wait for mm_ready=1, then go to SEND.
- SEND: drive mm_data_valid=1 and mm_data = opbuf[wcnt].
  - A word transfers on any cycle with mm_data_valid=1 and mm_ready=1; wcnt then increments.
  - Words go in order 0..31 (A then B).
  - After the transfer of word 31: drop mm_data_valid next cycle and go to WAIT_DD.
- WAIT_DD: wait for mm_data_done=1, then go to READ.
- READ: capture a word on any cycle with mm_calc_done=1 and mm_read_done=0.
  - resbuf[rcnt] <= mm_result; rcnt increments.
  - mm_read_done=1 on the following cycle for exactly one cycle. No capture occurs in the pulse cycle, so at most one word per 2 cycles.
  - After the 16th capture and its read_done pulse, go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- busy=1 in WAIT_RDY, SEND, WAIT_DD and READ only.
- Watchdog:
  - Counter resets on every operand transfer, every result capture, and every state change.
  - Otherwise it increments while busy.
  - If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES: set err=1, drop mm_data_valid and mm_read_done, go to IDLE. done is not pulsed.
  - A partial result buffer keeps any words already written.
- Result read: rd_data <= resbuf[rd_addr] every cycle, in all states. Reads during a job may return stale data.
- Simultaneous events:
  - Final transfer (word 31) and mm_data_done in the same cycle: go straight to READ.
  - mm_data_done arriving early during SEND is ignored.
  - mm_calc_done during SEND or WAIT_DD is ignored.
- Reset mid-job: immediate abort to IDLE with all outputs at reset values. The core is expected to be reset by the same iRstn.

Test Plan:
- Identity x B: load A=I (1.0=0x3F800000 on diagonal, 0 elsewhere), B[i]=float(i+1), start, core model always ready -> 32 transfers in 32 consecutive cycles, word 16 = 0x3F800000; resbuf equals B; done pulses once; err=0.
- Backpressure: core model toggles mm_ready every 3 cycles during SEND -> exactly 32 transfers, order 0..31, no duplicate or skipped word; mm_data stable while mm_ready=0.
- Result pacing: core holds mm_calc_done=1 continuously with a new result after each read_done -> exactly 16 mm_read_done pulses each 1 cycle wide, no double capture; rd_addr=5 returns the 6th result one cycle later.
- Watchdog: TIMEOUT_CYCLES=16, core never asserts mm_data_done -> err=1 exactly 16 cycles after the last transfer, busy=0, no done; next start clears err.
- Ignored inputs: start and wr_en to addr 0 with data 0xDEADBEEF during SEND -> job unaffected; opbuf[0] unchanged on the next job.
- Reset mid-READ: drop iRstn after 7 captures -> all outputs 0 asynchronously, state IDLE; a new job after release completes with correct results.
